// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out converter. A WIDTH-bit word is accepted through a
//   valid/ready handshake and emitted LSB first, one bit per clock, starting
//   the cycle after acceptance. A new word may be accepted during the
//   last-bit cycle, so consecutive words stream with no idle gap.
//
// Ports
//   clk         in   single clock, rising-edge
//   reset_n     in   asynchronous active-low reset
//   load_data   in   [WIDTH-1:0] parallel word to serialize
//   load_valid  in   load_data is valid this cycle
//   load_ready  out  block can accept a word this cycle
//   s_out       out  serial bit, LSB first
//   s_valid     out  s_out carries a valid bit this cycle
//   frame_done  out  pulse coincident with the last bit of a word
//   busy        out  high while shifting
// -----------------------------------------------------------------------------
module piso_serializer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             s_out,
   output logic             s_valid,
   output logic             frame_done,
   output logic             busy
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   // Holds load_ready low until the first clock edge after reset release.
   logic             ready_en_reg;
   logic [WIDTH-1:0] shifted;
   logic             last_bit;
   logic             accept;

   // Right shift by one with zero fill at the top.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (gi == WIDTH - 1) begin : g_top
            assign shifted[gi] = 1'b0;
         end else begin : g_body
            assign shifted[gi] = shift_reg[gi + 1];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         shift_reg    <= '0;
         cnt_reg      <= '0;
         ready_en_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         cnt_reg      <= cnt_next;
         ready_en_reg <= 1'b1;
      end
   end

   // Outputs depend only on registered state, so they change only on a clock
   // edge (or on reset) and never follow load_* combinationally, except
   // load_ready which is itself a function of state only.
   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      cnt_next   = cnt_reg;

      last_bit   = (state_reg == SHIFT) && (cnt_reg == LAST_CNT);
      load_ready = ready_en_reg && ((state_reg == IDLE) || last_bit);
      accept     = load_valid && load_ready;

      busy       = (state_reg == SHIFT);
      s_valid    = (state_reg == SHIFT);
      s_out      = (state_reg == SHIFT) && shift_reg[0];
      frame_done = last_bit;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               shift_next = load_data;
               cnt_next   = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (accept) begin
               // Back-to-back: only reachable during the last bit.
               shift_next = load_data;
               cnt_next   = '0;
            end else if (last_bit) begin
               shift_next = '0;
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               shift_next = shifted;
               cnt_next   = cnt_reg + CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] load_data;
   logic       load_valid;
   logic       load_ready, s_out, s_valid, frame_done, busy;

   logic [7:0] load_data8;
   logic       load_valid8;
   logic       load_ready8, s_out8, s_valid8, frame_done8, busy8;

   int n_checks = 0;
   int n_fail   = 0;

   logic exp_bit_q[$];
   logic exp_fd_q[$];

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(4)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .s_out      (s_out),
      .s_valid    (s_valid),
      .frame_done (frame_done),
      .busy       (busy)
   );

   piso_serializer #(.WIDTH(8)) u_dut8 (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_data  (load_data8),
      .load_valid (load_valid8),
      .load_ready (load_ready8),
      .s_out      (s_out8),
      .s_valid    (s_valid8),
      .frame_done (frame_done8),
      .busy       (busy8)
   );

   // Scoreboard producer: expected serial stream of a word, LSB first.
   task automatic push_word(input logic [31:0] w, input int width);
      for (int i = 0; i < width; i++) begin
         exp_bit_q.push_back(w[i]);
         exp_fd_q.push_back(i == width - 1);
      end
   endtask

   task automatic test_reset;
      #1;
      n_checks++;
      if ({s_out, s_valid, frame_done, busy, load_ready} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_state: out/valid/fd/busy/ready=%b required 00000",
                  {s_out, s_valid, frame_done, busy, load_ready});
      end
      n_checks++;
      if ({s_out8, s_valid8, frame_done8, busy8, load_ready8} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_state_w8: out/valid/fd/busy/ready=%b required 00000",
                  {s_out8, s_valid8, frame_done8, busy8, load_ready8});
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (load_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold_ready: load_ready=%b required 0", load_ready);
      end
      reset_n = 1'b1;
      #1;
      n_checks++;
      if (load_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL release_before_edge: load_ready=%b required 0", load_ready);
      end
      @(negedge clk);
      n_checks++;
      if (load_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL release_after_edge: ready=%b busy=%b required ready=1 busy=0",
                  load_ready, busy);
      end
      $display("test_reset done");
   endtask

   task automatic test_idle;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if (s_valid !== 1'b0 || s_out !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle cyc%0d: valid=%b out=%b busy=%b ready=%b required 0 0 0 1",
                     i, s_valid, s_out, busy, load_ready);
         end
      end
      $display("test_idle done");
   endtask

   task automatic test_single;
      logic       b, f;
      logic [3:0] sipo;
      sipo = 4'b0;
      @(negedge clk);
      load_data  = 4'b1011;
      load_valid = 1'b1;
      push_word(32'(4'b1011), 4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         load_valid = 1'b0;
         load_data  = 4'b0100;   // post-acceptance change must be ignored
         b = exp_bit_q.pop_front();
         f = exp_fd_q.pop_front();
         n_checks++;
         if (s_valid !== 1'b1 || s_out !== b || frame_done !== f || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single bit%0d: valid=%b out=%b fd=%b busy=%b required 1 %b %b 1",
                     i, s_valid, s_out, frame_done, busy, b, f);
         end
         n_checks++;
         if (load_ready !== (i == 3)) begin
            n_fail++;
            $display("FAIL single ready%0d: load_ready=%b required %b", i, load_ready, (i == 3));
         end
         sipo = {s_out, sipo[3:1]};
      end
      @(negedge clk);
      n_checks++;
      if ({s_out, s_valid, frame_done, busy, load_ready} !== 5'b00001) begin
         n_fail++;
         $display("FAIL single_idle: out/valid/fd/busy/ready=%b required 00001",
                  {s_out, s_valid, frame_done, busy, load_ready});
      end
      n_checks++;
      if (sipo !== 4'b1011) begin
         n_fail++;
         $display("FAIL single_sipo: got %b required 1011", sipo);
      end
      $display("test_single done sipo=%b", sipo);
   endtask

   task automatic test_back_to_back;
      logic b, f;
      @(negedge clk);
      load_data  = 4'b1011;
      load_valid = 1'b1;
      push_word(32'(4'b1011), 4);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         b = exp_bit_q.pop_front();
         f = exp_fd_q.pop_front();
         n_checks++;
         if (s_valid !== 1'b1 || s_out !== b || frame_done !== f) begin
            n_fail++;
            $display("FAIL b2b bit%0d: valid=%b out=%b fd=%b required 1 %b %b",
                     i, s_valid, s_out, frame_done, b, f);
         end
         n_checks++;
         if (load_ready !== (i == 3 || i == 7)) begin
            n_fail++;
            $display("FAIL b2b ready%0d: load_ready=%b required %b",
                     i, load_ready, (i == 3 || i == 7));
         end
         if (i == 3) begin
            load_data  = 4'b0110;
            load_valid = 1'b1;
            push_word(32'(4'b0110), 4);
         end else begin
            load_valid = 1'b0;
         end
      end
      @(negedge clk);
      n_checks++;
      if (s_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle: valid=%b busy=%b required 0 0", s_valid, busy);
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_backpressure;
      logic b, f;
      @(negedge clk);
      load_data  = 4'b1001;
      load_valid = 1'b1;
      push_word(32'(4'b1001), 4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         b = exp_bit_q.pop_front();
         f = exp_fd_q.pop_front();
         n_checks++;
         if (s_valid !== 1'b1 || s_out !== b || frame_done !== f) begin
            n_fail++;
            $display("FAIL bp bit%0d: valid=%b out=%b fd=%b required 1 %b %b",
                     i, s_valid, s_out, frame_done, b, f);
         end
         n_checks++;
         if (load_ready !== (i == 3)) begin
            n_fail++;
            $display("FAIL bp ready%0d: load_ready=%b required %b", i, load_ready, (i == 3));
         end
         if (i < 3) begin
            load_valid = 1'b1;
            load_data  = 4'($urandom_range(0, 15));
         end else begin
            load_valid = 1'b0;
         end
      end
      @(negedge clk);
      n_checks++;
      if (s_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_idle: valid=%b busy=%b ready=%b required 0 0 1",
                  s_valid, busy, load_ready);
      end
      $display("test_backpressure done");
   endtask

   task automatic test_reset_mid;
      logic b, f;
      @(negedge clk);
      load_data  = 4'b1011;
      load_valid = 1'b1;
      push_word(32'(4'b1011), 4);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         load_valid = 1'b0;
         b = exp_bit_q.pop_front();
         f = exp_fd_q.pop_front();
         n_checks++;
         if (s_valid !== 1'b1 || s_out !== b || frame_done !== f) begin
            n_fail++;
            $display("FAIL rstmid bit%0d: valid=%b out=%b fd=%b required 1 %b %b",
                     i, s_valid, s_out, frame_done, b, f);
         end
      end
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      exp_bit_q.delete();
      exp_fd_q.delete();
      #1;
      n_checks++;
      if ({s_out, s_valid, frame_done, busy, load_ready} !== 5'b0) begin
         n_fail++;
         $display("FAIL rstmid_async: out/valid/fd/busy/ready=%b required 00000",
                  {s_out, s_valid, frame_done, busy, load_ready});
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (frame_done !== 1'b0 || s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_hold%0d: fd=%b valid=%b required 0 0", i, frame_done, s_valid);
         end
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (load_ready !== 1'b1 || s_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_release: ready=%b valid=%b required 1 0", load_ready, s_valid);
      end
      load_data  = 4'b0001;
      load_valid = 1'b1;
      push_word(32'(4'b0001), 4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         load_valid = 1'b0;
         b = exp_bit_q.pop_front();
         f = exp_fd_q.pop_front();
         n_checks++;
         if (s_valid !== 1'b1 || s_out !== b || frame_done !== f) begin
            n_fail++;
            $display("FAIL rstmid_new bit%0d: valid=%b out=%b fd=%b required 1 %b %b",
                     i, s_valid, s_out, frame_done, b, f);
         end
      end
      @(negedge clk);
      n_checks++;
      if (s_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_idle: valid=%b required 0", s_valid);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_width8;
      logic b, f;
      @(negedge clk);
      n_checks++;
      if (load_ready8 !== 1'b1) begin
         n_fail++;
         $display("FAIL w8_ready: load_ready=%b required 1", load_ready8);
      end
      load_data8  = 8'hA5;
      load_valid8 = 1'b1;
      push_word(32'(8'hA5), 8);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         load_valid8 = 1'b0;
         load_data8  = 8'h00;
         b = exp_bit_q.pop_front();
         f = exp_fd_q.pop_front();
         n_checks++;
         if (s_valid8 !== 1'b1 || s_out8 !== b || frame_done8 !== f) begin
            n_fail++;
            $display("FAIL w8 bit%0d: valid=%b out=%b fd=%b required 1 %b %b",
                     i, s_valid8, s_out8, frame_done8, b, f);
         end
      end
      @(negedge clk);
      n_checks++;
      if (s_valid8 !== 1'b0 || busy8 !== 1'b0 || frame_done8 !== 1'b0) begin
         n_fail++;
         $display("FAIL w8_idle: valid=%b busy=%b fd=%b required 0 0 0",
                  s_valid8, busy8, frame_done8);
      end
      $display("test_width8 done");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      load_data   = '0;
      load_valid  = 1'b0;
      load_data8  = '0;
      load_valid8 = 1'b0;
      test_reset;
      test_idle;
      test_single;
      test_back_to_back;
      test_backpressure;
      test_reset_mid;
      test_width8;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
